// File: rtl/muldiv_pkg.sv
// Op codes and FSM states shared by the iterative multiply/divide unit and EXE decode.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 signed/unsigned multiply and restoring divide, one bit per cycle: WIDTH+1 cycles
// from accept to valid_o (1 for divide-by-zero); start_i is ignored while busy_o, cancel_i aborts.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_e      r_state;
  muldiv_op_e         r_op;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_sa;
  logic               r_sb;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  muldiv_op_e         w_op;
  logic               w_in_div;
  logic               w_in_signed;
  logic               w_accept;
  logic               w_run_div;
  logic               w_run_signed;
  logic               w_sub;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH+1:0]   w_diff;
  logic [2*WIDTH-1:0] w_step;

  function automatic logic [2*WIDTH-1:0] sign_fix(input logic is_div, input logic is_signed,
                                                  input logic sa, input logic sb,
                                                  input logic [2*WIDTH-1:0] raw);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    q = raw[WIDTH-1:0];
    r = raw[2*WIDTH-1:WIDTH];
    if (!is_signed) return raw;
    if (!is_div) return (sa ^ sb) ? -raw : raw;
    if (sa ^ sb) q = -q;
    if (sa) r = -r;
    return {r, q};
  endfunction

  assign w_op        = muldiv_op_e'(op_i);
  assign w_in_div    = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_in_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
  assign w_accept    = start_i && !cancel_i && (r_state != ST_RUN);

  // MIN negates to itself, which read as unsigned is exactly 2^(WIDTH-1).
  assign w_mag_a = (w_in_signed && a_i[WIDTH-1]) ? -a_i : a_i;
  assign w_mag_b = (w_in_signed && b_i[WIDTH-1]) ? -b_i : b_i;

  assign w_run_div    = (r_op == OP_DIV) || (r_op == OP_DIVU);
  assign w_run_signed = (r_op == OP_MULT) || (r_op == OP_DIV);

  assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  // Partial remainder is WIDTH+1 bits after the shift; a set top bit of w_diff means borrow.
  assign w_diff = {1'b0, r_acc[2*WIDTH-1:WIDTH-1]} - {2'b00, r_opnd};
  assign w_sub  = (w_diff[WIDTH+1:WIDTH] == 2'b00);

  always_comb begin
    w_step = {w_sum, r_acc[WIDTH-1:1]};
    if (w_run_div) begin
      w_step = w_sub ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                     : {r_acc[2*WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MULT;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_dbz <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (cancel_i) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_step;
            if (r_cnt == '0) begin
              r_state      <= ST_DONE;
              {r_hi, r_lo} <= sign_fix(w_run_div, w_run_signed, r_sa, r_sb, w_step);
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          if (w_accept) begin
            r_op  <= w_op;
            r_sa  <= w_in_signed & a_i[WIDTH-1];
            r_sb  <= w_in_signed & b_i[WIDTH-1];
            r_cnt <= CW'(WIDTH - 1);
            if (w_in_div && (b_i == '0)) begin
              r_state <= ST_DONE;
              r_dbz   <= 1'b1;
              r_hi    <= a_i;
              r_lo    <= '1;
            end else if (w_in_div) begin
              r_state <= ST_RUN;
              r_opnd  <= w_mag_b;
              r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
            end else begin
              r_state <= ST_RUN;
              r_opnd  <= w_mag_a;
              r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
            end
          end
        end
      endcase
    end
  end

  assign busy_o        = (r_state == ST_RUN);
  assign valid_o       = (r_state == ST_DONE);
  assign div_by_zero_o = r_dbz;
  assign hi_o          = r_hi;
  assign lo_o          = r_lo;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: directed 32-bit cases, timing/cancel/reset scenarios, random 8-bit ops vs a model.
module tb_muldiv_iter;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        s32, c32;
  logic [1:0]  op32;
  logic [31:0] a32, b32;
  logic        busy32, v32, dz32;
  logic [31:0] hi32, lo32;
  logic        s8, c8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, v8, dz8;
  logic [7:0]  hi8, lo8;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  muldiv_iter #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start_i(s32), .op_i(op32), .a_i(a32), .b_i(b32),
    .cancel_i(c32), .busy_o(busy32), .valid_o(v32), .hi_o(hi32), .lo_o(lo32),
    .div_by_zero_o(dz32)
  );

  muldiv_iter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start_i(s8), .op_i(op8), .a_i(a8), .b_i(b8),
    .cancel_i(c8), .busy_o(busy8), .valid_o(v8), .hi_o(hi8), .lo_o(lo8),
    .div_by_zero_o(dz8)
  );

  // Reference result {hi, lo} from plain integer arithmetic on w-bit operands.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
    logic [63:0] mask, ua, ub, pp, hi, lo;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = a[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb = b[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    hi = '0;
    lo = '0;
    if (op == 2'b00 || op == 2'b01) begin
      pp = (op == 2'b00) ? 64'(sa * sb) : ua * ub;
      hi = (pp >> w) & mask;
      lo = pp & mask;
    end else if (ub == 64'd0) begin
      hi = ua;
      lo = mask;
    end else if (op == 2'b10) begin
      q  = sa / sb;
      r  = sa % sb;
      hi = 64'(r) & mask;
      lo = 64'(q) & mask;
    end else begin
      hi = ua % ub;
      lo = ua / ub;
    end
    return {hi[31:0], lo[31:0]};
  endfunction

  task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    s32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(negedge clk);
    s32 = 1'b0;
    lat = 1;
    while (v32 !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s32 = 1'b0; c32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
    s8  = 1'b0; c8  = 1'b0; op8  = 2'b00; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy32, v32, dz32} !== 3'b000) begin
      failures++; $display("FAIL reset_flags32 got=%b exp=000", {busy32, v32, dz32});
    end
    checks++;
    if (hi32 !== 32'd0 || lo32 !== 32'd0) begin
      failures++; $display("FAIL reset_hilo32 got=%h_%h exp=0_0", hi32, lo32);
    end
    checks++;
    if ({busy8, v8, dz8} !== 3'b000) begin
      failures++; $display("FAIL reset_flags8 got=%b exp=000", {busy8, v8, dz8});
    end
    checks++;
    if (hi8 !== 8'd0 || lo8 !== 8'd0) begin
      failures++; $display("FAIL reset_hilo8 got=%h_%h exp=0_0", hi8, lo8);
    end
  endtask

  task automatic test_divu_timing();
    s32 = 1'b1; op32 = OP_DIVU; a32 = 32'd100; b32 = 32'd7;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      s32 = 1'b0;
      checks++;
      if (busy32 !== (k <= 32)) begin
        failures++; $display("FAIL divu_busy cycle=%0d got=%b exp=%b", k, busy32, (k <= 32));
      end
      checks++;
      if (v32 !== (k == 33)) begin
        failures++; $display("FAIL divu_valid cycle=%0d got=%b exp=%b", k, v32, (k == 33));
      end
      if (k == 33) begin
        checks++;
        if (lo32 !== 32'd14 || hi32 !== 32'd2 || dz32 !== 1'b0) begin
          failures++; $display("FAIL divu_result got hi=%0d lo=%0d dz=%b exp hi=2 lo=14 dz=0", hi32, lo32, dz32);
        end
      end
    end
  endtask

  task automatic test_directed();
    vec_t tbl[7];
    int   lat;
    tbl[0] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[1] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[2] = '{OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[3] = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    tbl[4] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[5] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[6] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
    for (int i = 0; i < 7; i++) begin
      run32(tbl[i].op, tbl[i].a, tbl[i].b, lat);
      checks++;
      if (lat !== 33) begin
        failures++; $display("FAIL directed_latency case=%0d got=%0d exp=33", i, lat);
      end
      checks++;
      if (hi32 !== tbl[i].hi || lo32 !== tbl[i].lo || dz32 !== 1'b0) begin
        failures++;
        $display("FAIL directed_result case=%0d got=%h_%h dz=%b exp=%h_%h dz=0", i, hi32, lo32, dz32, tbl[i].hi, tbl[i].lo);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    logic [31:0] av[2];
    logic [1:0]  ov[2];
    av[0] = 32'd5;        ov[0] = OP_DIVU;
    av[1] = 32'hFFFFFFF9; ov[1] = OP_DIV;
    for (int i = 0; i < 2; i++) begin
      s32 = 1'b1; op32 = ov[i]; a32 = av[i]; b32 = 32'd0;
      @(negedge clk);
      s32 = 1'b0;
      checks++;
      if ({busy32, v32, dz32} !== 3'b011) begin
        failures++; $display("FAIL dz_flags case=%0d got=%b exp=011", i, {busy32, v32, dz32});
      end
      checks++;
      if (hi32 !== av[i] || lo32 !== 32'hFFFFFFFF) begin
        failures++; $display("FAIL dz_result case=%0d got=%h_%h exp=%h_ffffffff", i, hi32, lo32, av[i]);
      end
      @(negedge clk);
      checks++;
      if ({busy32, v32, dz32} !== 3'b000) begin
        failures++; $display("FAIL dz_after case=%0d got=%b exp=000", i, {busy32, v32, dz32});
      end
    end
  endtask

  task automatic test_cancel();
    int lat;
    run32(OP_DIVU, 32'd100, 32'd7, lat);
    checks++;
    if (hi32 !== 32'd2 || lo32 !== 32'd14) begin
      failures++; $display("FAIL cancel_setup got=%h_%h exp=2_14", hi32, lo32);
    end
    s32 = 1'b1; op32 = OP_DIV; a32 = 32'd1000; b32 = 32'd3;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (busy32 !== (k <= 10)) begin
        failures++; $display("FAIL cancel_busy cycle=%0d got=%b exp=%b", k, busy32, (k <= 10));
      end
      checks++;
      if (v32 !== 1'b0) begin
        failures++; $display("FAIL cancel_valid cycle=%0d got=%b exp=0", k, v32);
      end
      s32 = (k == 5);
      if (k == 5) begin op32 = OP_MULTU; a32 = 32'd3; b32 = 32'd3; end
      c32 = (k == 10);
    end
    checks++;
    if (hi32 !== 32'd2 || lo32 !== 32'd14) begin
      failures++; $display("FAIL cancel_hold got=%h_%h exp=2_14", hi32, lo32);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    run32(OP_MULTU, 32'd3, 32'd5, lat);
    checks++;
    if (hi32 !== 32'd0 || lo32 !== 32'd15) begin
      failures++; $display("FAIL rstmid_setup got=%h_%h exp=0_f", hi32, lo32);
    end
    s32 = 1'b1; op32 = OP_MULT; a32 = 32'd9; b32 = 32'd9;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      s32 = 1'b0;
      if (k == 11) begin
        checks++;
        if ({busy32, v32, dz32} !== 3'b000 || hi32 !== 32'd0 || lo32 !== 32'd0) begin
          failures++; $display("FAIL rstmid_outputs got=%b %h_%h exp=000 0_0", {busy32, v32, dz32}, hi32, lo32);
        end
      end
      rst = (k == 10);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      op = 2'($urandom); a = $urandom; b = $urandom | 32'd1;
      exp = ref_model(op, a, b, 32);
      s32 = 1'b1; op32 = op; a32 = a; b32 = b;
      @(negedge clk);
      s32 = 1'b0;
      checks++;
      if (busy32 !== 1'b1) begin
        failures++; $display("FAIL b2b_no_bubble op=%0d got=%b exp=1", i, busy32);
      end
      lat = 1;
      while (v32 !== 1'b1 && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== 33) begin
        failures++; $display("FAIL b2b_latency op=%0d got=%0d exp=33", i, lat);
      end
      checks++;
      if ({hi32, lo32} !== exp) begin
        failures++; $display("FAIL b2b_result op=%0d got=%h_%h exp=%h_%h", i, hi32, lo32, exp[63:32], exp[31:0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_cancel_in_done();
    int lat;
    run32(OP_MULTU, 32'd6, 32'd7, lat);
    checks++;
    if (lat !== 33 || lo32 !== 32'd42) begin
      failures++; $display("FAIL cdone_setup got lat=%0d lo=%0d exp lat=33 lo=42", lat, lo32);
    end
    c32 = 1'b1; s32 = 1'b1; op32 = OP_DIVU; a32 = 32'd9; b32 = 32'd0;
    @(negedge clk);
    c32 = 1'b0; s32 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy32, v32, dz32} !== 3'b000) begin
        failures++; $display("FAIL cdone_flags cycle=%0d got=%b exp=000", k, {busy32, v32, dz32});
      end
      @(negedge clk);
    end
    checks++;
    if (hi32 !== 32'd0 || lo32 !== 32'd42) begin
      failures++; $display("FAIL cdone_hold got=%h_%h exp=0_2a", hi32, lo32);
    end
  endtask

  task automatic test_random8();
    logic [7:0]  edges[4];
    logic [1:0]  op;
    logic [7:0]  a, b;
    logic [63:0] exp;
    logic        dz_exp;
    int          lat, sel;
    edges[0] = 8'h00; edges[1] = 8'h01; edges[2] = 8'hFF; edges[3] = 8'h80;
    for (int n = 0; n < 80; n++) begin
      op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0) b = edges[$urandom_range(0, 3)];
      if (sel == 1) a = 8'h80;
      exp    = ref_model(op, {24'd0, a}, {24'd0, b}, 8);
      dz_exp = op[1] && (b == 8'd0);
      s8 = 1'b1; op8 = op; a8 = a; b8 = b;
      @(negedge clk);
      s8 = 1'b0;
      lat = 1;
      while (v8 !== 1'b1 && lat < 30) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== (dz_exp ? 1 : 9)) begin
        failures++; $display("FAIL rand8_latency n=%0d op=%0d got=%0d exp=%0d", n, op, lat, dz_exp ? 1 : 9);
      end
      checks++;
      if (hi8 !== exp[39:32] || lo8 !== exp[7:0] || dz8 !== dz_exp) begin
        failures++;
        $display("FAIL rand8_result n=%0d op=%0d a=%h b=%h got=%h_%h dz=%b exp=%h_%h dz=%b",
                 n, op, a, b, hi8, lo8, dz8, exp[39:32], exp[7:0], dz_exp);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_divu_timing();
    test_directed();
    test_div_zero();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    test_cancel_in_done();
    test_random8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
